// File: rtl/m_ifetch.sv
// Instruction fetch stage: sequential PC generation, in-order imem requests, prefetch FIFO, redirect flush.
// Optional IFETCH_BYPASS_EN: an empty FIFO forwards a live response to the output in the same cycle.

module m_ifetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    output logic        w_imem_req_valid,
    output logic [31:0] w_imem_req_addr,
    input  logic        w_imem_req_ready,
    input  logic        w_imem_rsp_valid,
    input  logic [31:0] w_imem_rsp_data,
    input  logic        w_redirect,
    input  logic [31:0] w_redirect_pc,
    output logic        w_inst_valid,
    output logic [31:0] w_inst,
    output logic [31:0] w_inst_pc,
    input  logic        w_inst_ready
);

    localparam int               CNT_W    = $clog2(DEPTH) + 1;
    localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W:0]   DEPTH_W  = (CNT_W + 1)'(DEPTH);

    logic [31:0]      pc_q, pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] outst_q, outst_d;
    logic [CNT_W-1:0] drop_q, drop_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] pcq_rd_q, pcq_rd_d;
    logic [PTR_W-1:0] pcq_wr_q, pcq_wr_d;

    logic [31:0] fifo_inst_mem [DEPTH];
    logic [31:0] fifo_pc_mem   [DEPTH];
    logic [31:0] pcq_mem       [DEPTH];

    logic        req_fire;
    logic        rsp_keep;
    logic        byp_active;
    logic        push;
    logic        pop;
    logic        fifo_empty;
    logic [31:0] rsp_pc;
    logic [31:0] redirect_tgt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign redirect_tgt = w_redirect_pc & 32'hFFFF_FFFC;
    assign rsp_pc       = pcq_mem[pcq_rd_q];
    assign fifo_empty   = (count_q == '0);

    // Slots are reserved at request time so every returning word is guaranteed FIFO space.
    assign w_imem_req_valid = w_rst_n && !w_redirect &&
                              (({1'b0, count_q} + {1'b0, outst_q}) < DEPTH_W);
    assign w_imem_req_addr  = pc_q;
    assign req_fire         = w_imem_req_valid && w_imem_req_ready;

    assign rsp_keep = w_rst_n && w_imem_rsp_valid && (drop_q == '0) && !w_redirect;

`ifdef IFETCH_BYPASS_EN
    assign byp_active = rsp_keep && fifo_empty;
`else
    assign byp_active = 1'b0;
`endif

    assign pop  = !fifo_empty && w_inst_ready && !w_redirect;
    assign push = rsp_keep && !(byp_active && w_inst_ready);

    always_comb begin
        w_inst_valid = 1'b0;
        w_inst       = '0;
        w_inst_pc    = '0;
        if (!fifo_empty) begin
            w_inst_valid = 1'b1;
            w_inst       = fifo_inst_mem[rd_ptr_q];
            w_inst_pc    = fifo_pc_mem[rd_ptr_q];
        end else if (byp_active) begin
            w_inst_valid = 1'b1;
            w_inst       = w_imem_rsp_data;
            w_inst_pc    = rsp_pc;
        end
    end

    always_comb begin
        pc_d     = pc_q;
        count_d  = count_q;
        drop_d   = drop_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        outst_d  = outst_q + CNT_W'(req_fire) - CNT_W'(w_imem_rsp_valid);
        pcq_wr_d = req_fire ? ptr_inc(pcq_wr_q) : pcq_wr_q;
        pcq_rd_d = w_imem_rsp_valid ? ptr_inc(pcq_rd_q) : pcq_rd_q;

        // The PC queue keeps running across a redirect so stale responses still pair correctly.
        if (w_redirect) begin
            pc_d     = redirect_tgt;
            count_d  = '0;
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            drop_d   = outst_d;
        end else begin
            if (req_fire) begin
                pc_d = pc_q + 32'd4;
            end
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
            if (w_imem_rsp_valid && (drop_q != '0)) begin
                drop_d = drop_q - 1'b1;
            end
        end
    end

    always_ff @(posedge w_clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            pc_q     <= RESET_PC;
            count_q  <= '0;
            outst_q  <= '0;
            drop_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            pcq_rd_q <= '0;
            pcq_wr_q <= '0;
        end else begin
            pc_q     <= pc_d;
            count_q  <= count_d;
            outst_q  <= outst_d;
            drop_q   <= drop_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            pcq_rd_q <= pcq_rd_d;
            pcq_wr_q <= pcq_wr_d;
        end
    end

    always_ff @(posedge w_clk) begin
        if (push) begin
            fifo_inst_mem[wr_ptr_q] <= w_imem_rsp_data;
            fifo_pc_mem[wr_ptr_q]   <= rsp_pc;
        end
        if (req_fire) begin
            pcq_mem[pcq_wr_q] <= pc_q;
        end
    end

    a_rsp_has_outstanding: assert property (@(posedge w_clk) disable iff (!w_rst_n)
        w_imem_rsp_valid |-> (outst_q != '0));

    a_occupancy: assert property (@(posedge w_clk) disable iff (!w_rst_n)
        ((({1'b0, count_q} + {1'b0, outst_q}) <= DEPTH_W) && (drop_q <= outst_q)));

endmodule

// File: tb/tb_m_ifetch.sv
// Self-checking bench for m_ifetch: behavioural memory with variable latency plus an in-order scoreboard.
// Honours IFETCH_BYPASS_EN when computing same-cycle delivery expectations.

module tb_m_ifetch;

    localparam logic [31:0] KEY = 32'hA5A5_0000;
`ifdef IFETCH_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } exp_t;

    logic        w_clk = 1'b0;
    logic        w_rst_n;
    logic        w_imem_req_valid;
    logic [31:0] w_imem_req_addr;
    logic        w_imem_req_ready;
    logic        w_imem_rsp_valid = 1'b0;
    logic [31:0] w_imem_rsp_data  = 32'h0;
    logic        w_redirect;
    logic [31:0] w_redirect_pc;
    logic        w_inst_valid;
    logic [31:0] w_inst;
    logic [31:0] w_inst_pc;
    logic        w_inst_ready;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    int          mem_lat  = 1;
    int          n_req    = 0;
    logic [31:0] model_pc = 32'h0;
    exp_t        exp_e;

    mreq_t       mem_q[$];
    exp_t        exp_q[$];
    logic [31:0] got_pc[$];
    int          got_cyc[$];

    m_ifetch #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .w_clk            (w_clk),
        .w_rst_n          (w_rst_n),
        .w_imem_req_valid (w_imem_req_valid),
        .w_imem_req_addr  (w_imem_req_addr),
        .w_imem_req_ready (w_imem_req_ready),
        .w_imem_rsp_valid (w_imem_rsp_valid),
        .w_imem_rsp_data  (w_imem_rsp_data),
        .w_redirect       (w_redirect),
        .w_redirect_pc    (w_redirect_pc),
        .w_inst_valid     (w_inst_valid),
        .w_inst           (w_inst),
        .w_inst_pc        (w_inst_pc),
        .w_inst_ready     (w_inst_ready)
    );

    always #5 w_clk = ~w_clk;

    // Memory bookkeeping, PC model and scoreboard, all on pre-edge values.
    always @(posedge w_clk) begin
        cyc = cyc + 1;
        if (!w_rst_n) begin
            mem_q.delete();
            exp_q.delete();
            model_pc = 32'h0;
        end else begin
            if (w_imem_rsp_valid && (mem_q.size() > 0)) begin
                void'(mem_q.pop_front());
            end
            if (w_redirect) begin
                exp_q.delete();
                model_pc = w_redirect_pc & 32'hFFFF_FFFC;
            end else begin
                if (w_inst_valid && w_inst_ready) begin
                    got_pc.push_back(w_inst_pc);
                    got_cyc.push_back(cyc);
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("[TB] FAIL sb_unexpected: got pc %h inst %h, required no delivery", w_inst_pc, w_inst);
                    end else begin
                        exp_e = exp_q.pop_front();
                        if ({w_inst, w_inst_pc} !== {exp_e.inst, exp_e.pc}) begin
                            n_fail++;
                            $display("[TB] FAIL sb_data: got pc %h inst %h, required pc %h inst %h",
                                     w_inst_pc, w_inst, exp_e.pc, exp_e.inst);
                        end
                    end
                end
                if (w_imem_req_valid && w_imem_req_ready) begin
                    n_req++;
                    n_checks++;
                    if (w_imem_req_addr !== model_pc) begin
                        n_fail++;
                        $display("[TB] FAIL req_addr: got %h required %h", w_imem_req_addr, model_pc);
                    end
                    mem_q.push_back('{addr: w_imem_req_addr, due: cyc + mem_lat});
                    exp_q.push_back('{inst: model_pc ^ KEY, pc: model_pc});
                    model_pc = model_pc + 32'd4;
                end
            end
        end
    end

    always @(negedge w_clk) begin
        if ((mem_q.size() > 0) && (mem_q[0].due <= cyc + 1)) begin
            w_imem_rsp_valid = 1'b1;
            w_imem_rsp_data  = mem_q[0].addr ^ KEY;
        end else begin
            w_imem_rsp_valid = 1'b0;
            w_imem_rsp_data  = 32'h0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no end of test, required finish before 200000");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic do_reset(input int lat, input logic in_rdy);
        @(negedge w_clk);
        w_rst_n          = 1'b0;
        w_redirect       = 1'b0;
        w_redirect_pc    = 32'h0;
        w_imem_req_ready = 1'b1;
        w_inst_ready     = in_rdy;
        mem_lat          = lat;
        repeat (2) @(negedge w_clk);
        got_pc.delete();
        got_cyc.delete();
        n_req   = 0;
        w_rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge w_clk);
        #1;
        n_checks += 4;
        if (w_imem_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_req_valid: got %b required 0", w_imem_req_valid); end
        if (w_inst_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rst_inst_valid: got %b required 0", w_inst_valid); end
        if (w_inst !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_inst: got %h required 0", w_inst); end
        if (w_inst_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_inst_pc: got %h required 0", w_inst_pc); end
        repeat (2) @(negedge w_clk);
        w_rst_n = 1'b1;
        #1;
        n_checks += 2;
        if (w_imem_req_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL first_req_valid: got %b required 1", w_imem_req_valid); end
        if (w_imem_req_addr !== 32'h0) begin n_fail++; $display("[TB] FAIL first_req_addr: got %h required 0", w_imem_req_addr); end
        w_inst_ready = 1'b1;
        repeat (6) @(negedge w_clk);
        @(posedge w_clk);
        #2;
        n_checks++;
        if (w_inst_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL pre_async_valid: got %b required 1", w_inst_valid); end
        w_rst_n = 1'b0;
        #1;
        n_checks += 3;
        if (w_inst_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL async_inst_valid: got %b required 0", w_inst_valid); end
        if (w_imem_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL async_req_valid: got %b required 0", w_imem_req_valid); end
        if (w_inst_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL async_inst_pc: got %h required 0", w_inst_pc); end
    endtask

    task automatic test_stream();
        do_reset(1, 1'b1);
        for (int i = 0; i < 40 && got_pc.size() < 6; i++) @(negedge w_clk);
        n_checks++;
        if (got_pc.size() < 6) begin
            n_fail++;
            $display("[TB] FAIL stream_timeout: got %0d deliveries required 6", got_pc.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (got_pc[i] !== 32'(4 * i)) begin
                    n_fail++;
                    $display("[TB] FAIL stream_pc%0d: got %h required %h", i, got_pc[i], 32'(4 * i));
                end
            end
            for (int i = 0; i < 4; i++) begin
                n_checks++;
                if (got_cyc[i + 1] - got_cyc[i] != 1) begin
                    n_fail++;
                    $display("[TB] FAIL stream_rate%0d: got gap %0d required 1", i, got_cyc[i + 1] - got_cyc[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        do_reset(1, 1'b0);
        repeat (12) @(negedge w_clk);
        #1;
        n_checks += 4;
        if (n_req != 4) begin n_fail++; $display("[TB] FAIL full_req_count: got %0d required 4", n_req); end
        if (w_imem_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL full_req_valid: got %b required 0", w_imem_req_valid); end
        if (w_inst_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL full_inst_valid: got %b required 1", w_inst_valid); end
        if (w_inst_pc !== 32'h0) begin n_fail++; $display("[TB] FAIL full_head_pc: got %h required 0", w_inst_pc); end
        w_inst_ready = 1'b1;
        for (int i = 0; i < 40 && got_pc.size() < 6; i++) @(negedge w_clk);
        n_checks++;
        if (got_pc.size() < 6) begin
            n_fail++;
            $display("[TB] FAIL drain_timeout: got %0d deliveries required 6", got_pc.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (got_pc[i] !== 32'(4 * i)) begin
                    n_fail++;
                    $display("[TB] FAIL drain_pc%0d: got %h required %h", i, got_pc[i], 32'(4 * i));
                end
            end
        end
    endtask

    task automatic test_redirect();
        do_reset(3, 1'b1);
        repeat (2) @(negedge w_clk);
        n_checks++;
        if (n_req != 2) begin n_fail++; $display("[TB] FAIL redir_outstanding: got %0d required 2", n_req); end
        w_redirect    = 1'b1;
        w_redirect_pc = 32'h0000_0103;
        #1;
        n_checks++;
        if (w_imem_req_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL redir_req_blocked: got %b required 0", w_imem_req_valid); end
        @(negedge w_clk);
        w_redirect = 1'b0;
        #1;
        n_checks += 2;
        if (w_imem_req_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL redir_req_valid: got %b required 1", w_imem_req_valid); end
        if (w_imem_req_addr !== 32'h100) begin n_fail++; $display("[TB] FAIL redir_req_addr: got %h required 100", w_imem_req_addr); end
        for (int i = 0; i < 40 && got_pc.size() < 2; i++) @(negedge w_clk);
        n_checks++;
        if (got_pc.size() < 2) begin
            n_fail++;
            $display("[TB] FAIL redir_timeout: got %0d deliveries required 2", got_pc.size());
        end else begin
            n_checks += 2;
            if (got_pc[0] !== 32'h100) begin n_fail++; $display("[TB] FAIL redir_first_pc: got %h required 100", got_pc[0]); end
            if (got_pc[1] !== 32'h104) begin n_fail++; $display("[TB] FAIL redir_second_pc: got %h required 104", got_pc[1]); end
        end
    endtask

    task automatic test_redirect_collision();
        bit found;
        int base;
        do_reset(2, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge w_clk);
            #2;
            if (w_imem_rsp_valid && w_inst_valid && w_inst_ready) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("[TB] FAIL coll_setup: got no response/pop overlap required one within 30 cycles");
        end else begin
            w_redirect    = 1'b1;
            w_redirect_pc = 32'h0000_2000;
            @(negedge w_clk);
            w_redirect = 1'b0;
            #1;
            n_checks++;
            if (w_inst_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL coll_flushed: got %b required 0", w_inst_valid); end
            base = got_pc.size();
            for (int i = 0; i < 40 && got_pc.size() < base + 2; i++) @(negedge w_clk);
            n_checks++;
            if (got_pc.size() < base + 2) begin
                n_fail++;
                $display("[TB] FAIL coll_timeout: got %0d deliveries required %0d", got_pc.size(), base + 2);
            end else begin
                n_checks += 2;
                if (got_pc[base] !== 32'h2000) begin n_fail++; $display("[TB] FAIL coll_first_pc: got %h required 2000", got_pc[base]); end
                if (got_pc[base + 1] !== 32'h2004) begin n_fail++; $display("[TB] FAIL coll_second_pc: got %h required 2004", got_pc[base + 1]); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int base;
        do_reset(3, 1'b1);
        repeat (5) @(negedge w_clk);
        w_redirect    = 1'b1;
        w_redirect_pc = 32'h0000_0300;
        @(negedge w_clk);
        w_redirect_pc = 32'hFFFF_FFFA;
        @(negedge w_clk);
        w_redirect = 1'b0;
        #1;
        n_checks++;
        if (w_imem_req_addr !== 32'hFFFF_FFF8) begin n_fail++; $display("[TB] FAIL b2b_req_addr: got %h required fffffff8", w_imem_req_addr); end
        base = got_pc.size();
        for (int i = 0; i < 50 && got_pc.size() < base + 3; i++) @(negedge w_clk);
        n_checks++;
        if (got_pc.size() < base + 3) begin
            n_fail++;
            $display("[TB] FAIL b2b_timeout: got %0d deliveries required %0d", got_pc.size(), base + 3);
        end else begin
            n_checks += 3;
            if (got_pc[base] !== 32'hFFFF_FFF8) begin n_fail++; $display("[TB] FAIL b2b_pc0: got %h required fffffff8", got_pc[base]); end
            if (got_pc[base + 1] !== 32'hFFFF_FFFC) begin n_fail++; $display("[TB] FAIL b2b_pc1: got %h required fffffffc", got_pc[base + 1]); end
            if (got_pc[base + 2] !== 32'h0) begin n_fail++; $display("[TB] FAIL b2b_wrap_pc: got %h required 0", got_pc[base + 2]); end
        end
    endtask

    task automatic test_bypass_timing();
        bit found;
        do_reset(1, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            @(negedge w_clk);
            #2;
            if (w_imem_rsp_valid) found = 1'b1;
        end
        n_checks++;
        if (!found) begin
            n_fail++;
            $display("[TB] FAIL byp_setup: got no response required one within 10 cycles");
        end else begin
            n_checks++;
            if (w_inst_valid !== BYP) begin n_fail++; $display("[TB] FAIL byp_same_cycle: got %b required %b", w_inst_valid, BYP); end
            @(negedge w_clk);
            #2;
            n_checks += 2;
            if (w_inst_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL byp_next_cycle: got %b required 1", w_inst_valid); end
            if (w_inst_pc !== (BYP ? 32'h4 : 32'h0)) begin
                n_fail++;
                $display("[TB] FAIL byp_next_pc: got %h required %h", w_inst_pc, (BYP ? 32'h4 : 32'h0));
            end
        end
    endtask

    task automatic test_random();
        int base;
        do_reset(2, 1'b1);
        base = got_pc.size();
        for (int i = 0; i < 300; i++) begin
            @(negedge w_clk);
            w_imem_req_ready = ($urandom_range(0, 3) != 0);
            w_inst_ready     = ($urandom_range(0, 2) != 0);
            mem_lat          = $urandom_range(1, 3);
            w_redirect       = ($urandom_range(0, 19) == 0);
            w_redirect_pc    = $urandom;
        end
        @(negedge w_clk);
        w_redirect = 1'b0;
        n_checks++;
        if (got_pc.size() - base <= 30) begin
            n_fail++;
            $display("[TB] FAIL rand_progress: got %0d deliveries required more than 30", got_pc.size() - base);
        end
    endtask

    initial begin
        w_rst_n          = 1'b0;
        w_imem_req_ready = 1'b1;
        w_redirect       = 1'b0;
        w_redirect_pc    = 32'h0;
        w_inst_ready     = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_redirect_collision();
        test_back_to_back();
        test_bypass_timing();
        test_random();
        repeat (2) @(negedge w_clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
